// File: rtl/dram_slot_arbiter_if.sv
// Signal bundle between the clock/video generator side and the DRAM slot arbiter.
// The generator (or a bench) drives through master; the arbiter uses slave.
`default_nettype none

interface dram_slot_arbiter_if;
  logic        PHI0;
  logic        RASn;
  logic        CASn;
  logic        AX;
  logic [5:0]  HCOL;
  logic [4:0]  SROW;
  logic [2:0]  LROW;
  logic        TEXT_MODE;
  logic        HIRES;
  logic        MIXED;
  logic        PAGE2;
  logic [15:0] CPU_A;
  logic        CPU_RW;
  logic [6:0]  MA;
  logic        MRASn;
  logic [2:0]  MCASn;
  logic        MWEn;
  logic        VID_LATCH;
  logic        CPU_LATCH;
  logic        SLOT_CPU;
  logic        CPU_RAM_HIT;
  logic [15:0] VID_ADDR;
  logic        PROTO_ERR;

  modport master (
    output PHI0, RASn, CASn, AX, HCOL, SROW, LROW, TEXT_MODE, HIRES, MIXED, PAGE2,
           CPU_A, CPU_RW,
    input  MA, MRASn, MCASn, MWEn, VID_LATCH, CPU_LATCH, SLOT_CPU, CPU_RAM_HIT,
           VID_ADDR, PROTO_ERR
  );

  modport slave (
    input  PHI0, RASn, CASn, AX, HCOL, SROW, LROW, TEXT_MODE, HIRES, MIXED, PAGE2,
           CPU_A, CPU_RW,
    output MA, MRASn, MCASn, MWEn, VID_LATCH, CPU_LATCH, SLOT_CPU, CPU_RAM_HIT,
           VID_ADDR, PROTO_ERR
  );
endinterface

`default_nettype wire

// File: rtl/dram_slot_arbiter.sv
// DRAM slot arbiter: splits each 14M memory cycle between the 6502 and the video
// scanner, builds the scan address and drives the multiplexed DRAM bus.
`default_nettype none

module dram_slot_arbiter #(
  parameter int          RAM_BANKS  = 3,
  parameter logic [15:0] TEXT_BASE  = 16'h0400,
  parameter logic [15:0] HIRES_BASE = 16'h2000
) (
  input logic           CLK_14o3M,
  input logic           RESET,
  dram_slot_arbiter_if.slave bus
);

  localparam logic [16:0] RAM_TOP = 17'(RAM_BANKS * 16384);

  typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

  state_t      state, state_nx;
  logic        ras_q, cas_q;
  logic        ras_fall, ras_rise, cas_fall, cas_rise;
  logic        set_err, fire, start, active, hit, write_cyc;
  logic [1:0]  bank;
  logic [15:0] vid_off, vid_next, addr_cur, text_base, hires_base;
  logic        force_text, hires_sel;

  logic [15:0] lat_cpu_a;
  logic        lat_rw;
  logic        slot_cpu, ram_hit, proto_err;
  logic [15:0] vid_addr;
  logic [6:0]  ma;
  logic        mras_n, mwe_n, vid_latch, cpu_latch;
  logic [2:0]  mcas_n;

  assign ras_fall = ras_q & ~bus.RASn;
  assign ras_rise = ~ras_q & bus.RASn;
  assign cas_fall = cas_q & ~bus.CASn;
  assign cas_rise = ~cas_q & bus.CASn;

  always_comb begin
    state_nx = state;
    set_err  = 1'b0;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cas_fall) set_err = 1'b1;
        if (ras_fall) state_nx = ROW;
      end
      ROW: begin
        if (ras_rise) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end else if (cas_fall) begin
          state_nx = COL;
        end
      end
      COL: begin
        if (cas_rise) begin
          fire     = 1'b1;
          state_nx = ras_rise ? IDLE : DONE;
        end else if (ras_rise) begin
          state_nx = IDLE;
          set_err  = 1'b1;
        end
      end
      DONE: begin
        if (ras_rise) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Video scan address: 8 interleaved row groups of 128 bytes, 3 thirds of 40 bytes.
  always_comb begin
    vid_off    = {6'd0, bus.SROW[2:0], 7'd0} + (16'(bus.SROW[4:3]) * 16'd40)
               + {10'd0, bus.HCOL};
    text_base  = bus.PAGE2 ? {TEXT_BASE[14:0], 1'b0} : TEXT_BASE;
    hires_base = bus.PAGE2 ? {HIRES_BASE[14:0], 1'b0} : HIRES_BASE;
    force_text = bus.MIXED & (bus.SROW >= 5'd20);
    hires_sel  = ~bus.TEXT_MODE & bus.HIRES & ~force_text;
    vid_next   = hires_sel ? (hires_base + {3'd0, bus.LROW, 10'd0} + vid_off)
                           : (text_base + vid_off);
  end

  assign start     = (state == IDLE) & ras_fall;
  assign active    = (state != IDLE);
  assign hit       = slot_cpu ? ram_hit : 1'b1;
  assign bank      = slot_cpu ? lat_cpu_a[15:14] : vid_addr[15:14];
  assign addr_cur  = start ? (bus.PHI0 ? bus.CPU_A : vid_next)
                           : (slot_cpu ? lat_cpu_a : vid_addr);
  assign write_cyc = slot_cpu & ~lat_rw & ram_hit & ~ras_rise &
                     (((state == ROW) & cas_fall) | (state == COL) | (state == DONE));

  always_ff @(posedge CLK_14o3M or posedge RESET) begin
    if (RESET) begin
      // Edge history resets "low" so strobes held low through reset are not seen as falls.
      ras_q     <= 1'b0;
      cas_q     <= 1'b0;
      state     <= IDLE;
      lat_cpu_a <= 16'd0;
      lat_rw    <= 1'b1;
      slot_cpu  <= 1'b0;
      ram_hit   <= 1'b0;
      vid_addr  <= 16'd0;
      proto_err <= 1'b0;
      ma        <= 7'd0;
      mras_n    <= 1'b1;
      mcas_n    <= 3'b111;
      mwe_n     <= 1'b1;
      vid_latch <= 1'b0;
      cpu_latch <= 1'b0;
    end else begin
      ras_q <= bus.RASn;
      cas_q <= bus.CASn;
      state <= state_nx;
      if (set_err) proto_err <= 1'b1;
      if (start) begin
        slot_cpu <= bus.PHI0;
        if (bus.PHI0) begin
          lat_cpu_a <= bus.CPU_A;
          lat_rw    <= bus.CPU_RW;
          ram_hit   <= ({1'b0, bus.CPU_A} < RAM_TOP);
        end else begin
          vid_addr <= vid_next;
        end
      end
      ma     <= bus.AX ? addr_cur[6:0] : addr_cur[13:7];
      mras_n <= bus.RASn | ~(start | active);
      for (int i = 0; i < 3; i++)
        mcas_n[i] <= ~(active & hit & (bank == 2'(i)) & ~bus.CASn);
      mwe_n     <= ~write_cyc;
      vid_latch <= fire & ~slot_cpu;
      cpu_latch <= fire & slot_cpu & lat_rw & ram_hit;
    end
  end

  assign bus.MA          = ma;
  assign bus.MRASn       = mras_n;
  assign bus.MCASn       = mcas_n;
  assign bus.MWEn        = mwe_n;
  assign bus.VID_LATCH   = vid_latch;
  assign bus.CPU_LATCH   = cpu_latch;
  assign bus.SLOT_CPU    = slot_cpu;
  assign bus.CPU_RAM_HIT = ram_hit;
  assign bus.VID_ADDR    = vid_addr;
  assign bus.PROTO_ERR   = proto_err;

endmodule

`default_nettype wire

// File: tb/tb_dram_slot_arbiter.sv
// Directed bench for dram_slot_arbiter: strobe scoreboard plus per-slot bus checks,
// with a second instance built for a single populated bank.
`default_nettype none

module tb_dram_slot_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #35 clk = ~clk;

  dram_slot_arbiter_if bus ();
  dram_slot_arbiter_if bus1 ();

  dram_slot_arbiter #(.RAM_BANKS(3)) dut  (.CLK_14o3M(clk), .RESET(rst), .bus(bus.slave));
  dram_slot_arbiter #(.RAM_BANKS(1)) dut1 (.CLK_14o3M(clk), .RESET(rst), .bus(bus1.slave));

  assign bus1.PHI0      = bus.PHI0;
  assign bus1.RASn      = bus.RASn;
  assign bus1.CASn      = bus.CASn;
  assign bus1.AX        = bus.AX;
  assign bus1.HCOL      = bus.HCOL;
  assign bus1.SROW      = bus.SROW;
  assign bus1.LROW      = bus.LROW;
  assign bus1.TEXT_MODE = bus.TEXT_MODE;
  assign bus1.HIRES     = bus.HIRES;
  assign bus1.MIXED     = bus.MIXED;
  assign bus1.PAGE2     = bus.PAGE2;
  assign bus1.CPU_A     = bus.CPU_A;
  assign bus1.CPU_RW    = bus.CPU_RW;

  typedef struct packed {
    logic        is_cpu;
    logic [15:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  logic [6:0] ma_row, ma_col;
  logic [2:0] cas_mask, cas1_mask;
  int         mwe_low, vid_cnt, cpu_cnt, cpu1_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every latch pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (bus.VID_LATCH || bus.CPU_LATCH)) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, bus.VID_LATCH, bus.CPU_LATCH}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_kind", {30'd0, bus.VID_LATCH, bus.CPU_LATCH},
            mon_e.is_cpu ? 32'd1 : 32'd2);
        if (!mon_e.is_cpu) chk("sb_vid_addr", {16'd0, bus.VID_ADDR}, {16'd0, mon_e.addr});
        else               chk("sb_slot_cpu", {31'd0, bus.SLOT_CPU}, 32'd1);
      end
    end
  end

  task automatic clear_obs();
    ma_row = '0; ma_col = '0; cas_mask = '0; cas1_mask = '0;
    mwe_low = 0; vid_cnt = 0; cpu_cnt = 0; cpu1_cnt = 0;
  endtask

  task automatic step(input logic ras, input logic cas, input logic ax, input int phase);
    bus.RASn = ras; bus.CASn = cas; bus.AX = ax;
    @(negedge clk);
    cas_mask  |= ~bus.MCASn;
    cas1_mask |= ~bus1.MCASn;
    if (!bus.MWEn) mwe_low++;
    vid_cnt  += int'(bus.VID_LATCH);
    cpu_cnt  += int'(bus.CPU_LATCH);
    cpu1_cnt += int'(bus1.CPU_LATCH);
    if (phase == 1) ma_row = bus.MA;
    if (phase == 2) ma_col = bus.MA;
  endtask

  task automatic slot(input logic phi0, input logic [15:0] a, input logic rw);
    bus.PHI0 = phi0; bus.CPU_A = a; bus.CPU_RW = rw;
    clear_obs();
    step(1, 1, 1, 0); step(0, 1, 1, 1); step(0, 1, 1, 0); step(0, 1, 0, 2);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 1, 0);
  endtask

  task automatic vslot(input string tag, input logic [15:0] exp_addr, input logic [2:0] exp_mask);
    sb.push_back('{is_cpu: 1'b0, addr: exp_addr});
    slot(1'b0, 16'h0000, 1'b1);
    chk({tag, "_vid_cnt"}, vid_cnt, 1);
    chk({tag, "_vid_addr"}, {16'd0, bus.VID_ADDR}, {16'd0, exp_addr});
    chk({tag, "_cas_mask"}, {29'd0, cas_mask}, {29'd0, exp_mask});
    chk({tag, "_slot"}, {31'd0, bus.SLOT_CPU}, 32'd0);
  endtask

  task automatic set_video(input logic tm, input logic hr, input logic mx, input logic p2,
                           input logic [2:0] l, input logic [4:0] r, input logic [5:0] c);
    bus.TEXT_MODE = tm; bus.HIRES = hr; bus.MIXED = mx; bus.PAGE2 = p2;
    bus.LROW = l; bus.SROW = r; bus.HCOL = c;
  endtask

  initial begin
    rst = 1'b1;
    bus.PHI0 = 1'b0; bus.RASn = 1'b0; bus.CASn = 1'b0; bus.AX = 1'b1;
    bus.CPU_A = 16'h0000; bus.CPU_RW = 1'b1;
    set_video(1, 0, 0, 0, 3'd0, 5'd0, 6'd0);
    clear_obs();
    repeat (3) @(negedge clk);
    chk("in_reset_mras", {31'd0, bus.MRASn}, 32'd1);
    chk("in_reset_mcas", {29'd0, bus.MCASn}, 32'd7);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ma", {25'd0, bus.MA}, 32'd0);
    chk("rst_mras", {31'd0, bus.MRASn}, 32'd1);
    chk("rst_mcas", {29'd0, bus.MCASn}, 32'd7);
    chk("rst_mwe", {31'd0, bus.MWEn}, 32'd1);
    chk("rst_vid_latch", {31'd0, bus.VID_LATCH}, 32'd0);
    chk("rst_cpu_latch", {31'd0, bus.CPU_LATCH}, 32'd0);
    chk("rst_slot_cpu", {31'd0, bus.SLOT_CPU}, 32'd0);
    chk("rst_hit", {31'd0, bus.CPU_RAM_HIT}, 32'd0);
    chk("rst_vid_addr", {16'd0, bus.VID_ADDR}, 32'd0);
    chk("rst_proto_err", {31'd0, bus.PROTO_ERR}, 32'd0);

    vslot("text_r0", 16'h0400, 3'b001);
    chk("text_r0_ma_row", {25'd0, ma_row}, 32'h00);
    chk("text_r0_ma_col", {25'd0, ma_col}, 32'h08);
    set_video(1, 0, 0, 0, 3'd0, 5'd1, 6'd0);
    vslot("text_r1", 16'h0480, 3'b001);
    set_video(1, 0, 0, 0, 3'd0, 5'd8, 6'd0);
    vslot("text_r8", 16'h0428, 3'b001);
    set_video(1, 0, 0, 0, 3'd0, 5'd23, 6'd39);
    vslot("text_r23", 16'h07F7, 3'b001);
    chk("text_r23_ma_row", {25'd0, ma_row}, 32'h77);
    chk("text_r23_ma_col", {25'd0, ma_col}, 32'h0F);
    set_video(0, 1, 0, 1, 3'd7, 5'd23, 6'd39);
    vslot("hires_p2", 16'h5FF7, 3'b010);
    set_video(0, 1, 1, 1, 3'd7, 5'd23, 6'd39);
    vslot("mixed_p2", 16'h0BF7, 3'b001);
    set_video(0, 1, 1, 0, 3'd0, 5'd19, 6'd0);
    vslot("mixed_r19", 16'h21D0, 3'b001);
    set_video(0, 0, 0, 1, 3'd4, 5'd5, 6'd10);
    vslot("lores_p2", 16'h0A8A, 3'b001);
    chk("video_proto_err", {31'd0, bus.PROTO_ERR}, 32'd0);

    slot(1'b1, 16'h8123, 1'b0);
    chk("wr_slot_cpu", {31'd0, bus.SLOT_CPU}, 32'd1);
    chk("wr_hit", {31'd0, bus.CPU_RAM_HIT}, 32'd1);
    chk("wr_ma_row", {25'd0, ma_row}, 32'h23);
    chk("wr_ma_col", {25'd0, ma_col}, 32'h02);
    chk("wr_cas_mask", {29'd0, cas_mask}, 32'h4);
    chk("wr_mwe_low", mwe_low, 3);
    chk("wr_mwe_after", {31'd0, bus.MWEn}, 32'd1);
    chk("wr_cpu_latch", cpu_cnt, 0);

    sb.push_back('{is_cpu: 1'b1, addr: 16'h1234});
    slot(1'b1, 16'h1234, 1'b1);
    chk("rd_cpu_latch", cpu_cnt, 1);
    chk("rd_cas_mask", {29'd0, cas_mask}, 32'h1);
    chk("rd_mwe_low", mwe_low, 0);
    chk("rd1_cpu_latch", cpu1_cnt, 1);

    slot(1'b1, 16'hC030, 1'b1);
    chk("c030_hit", {31'd0, bus.CPU_RAM_HIT}, 32'd0);
    chk("c030_cas_mask", {29'd0, cas_mask}, 32'd0);
    chk("c030_cpu_latch", cpu_cnt, 0);

    sb.push_back('{is_cpu: 1'b1, addr: 16'h4000});
    slot(1'b1, 16'h4000, 1'b1);
    chk("4000_hit", {31'd0, bus.CPU_RAM_HIT}, 32'd1);
    chk("4000_cas_mask", {29'd0, cas_mask}, 32'h2);
    chk("4000_b1_hit", {31'd0, bus1.CPU_RAM_HIT}, 32'd0);
    chk("4000_b1_cas_mask", {29'd0, cas1_mask}, 32'd0);
    chk("4000_b1_cpu_latch", cpu1_cnt, 0);

    // Reset in the middle of a write access.
    bus.PHI0 = 1'b1; bus.CPU_A = 16'h0010; bus.CPU_RW = 1'b0;
    step(1, 1, 1, 0); step(0, 1, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("pre_reset_mwe", {31'd0, bus.MWEn}, 32'd0);
    #10 rst = 1'b1;
    #1;
    chk("async_rst_mras", {31'd0, bus.MRASn}, 32'd1);
    chk("async_rst_mcas", {29'd0, bus.MCASn}, 32'd7);
    chk("async_rst_mwe", {31'd0, bus.MWEn}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("release_mras", {31'd0, bus.MRASn}, 32'd1);
    chk("release_mcas", {29'd0, cas_mask}, 32'd0);
    chk("release_proto_err", {31'd0, bus.PROTO_ERR}, 32'd0);

    clear_obs();
    bus.PHI0 = 1'b0;
    step(1, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    chk("abort_proto_err", {31'd0, bus.PROTO_ERR}, 32'd1);
    chk("abort_vid_cnt", vid_cnt, 0);
    set_video(1, 0, 0, 0, 3'd0, 5'd0, 6'd0);
    vslot("after_abort", 16'h0400, 3'b001);
    chk("after_abort_proto_err", {31'd0, bus.PROTO_ERR}, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dram_slot_arbiter.md
Name: dram_slot_arbiter

Overview:
- Shares the 48K DRAM array between the 6502 and the video scanner, one access per 14M-derived memory cycle.
- Slot ownership comes from PHI0 at each RAS fall: low selects the video slot, high selects the CPU slot.
- Computes the video scan address (text/lores/hires, page 1/2, mixed mode) and multiplexes row/column addresses onto the 7-bit DRAM bus.
- Gates per-bank CAS and write enable, and issues data-latch strobes.
- Sits between the clock/video generator (PHI0, RASn, CASn, AX, scan counters) and the RAM banks and bus latches.

Parameters:
RAM_BANKS, 3, number of populated 16K banks (1..3); CPU addresses at or above RAM_BANKS*16K are not RAM hits.
TEXT_BASE, 16'h0400, text/lores page 1 base; page 2 is 2*TEXT_BASE.
HIRES_BASE, 16'h2000, hires page 1 base; page 2 is 2*HIRES_BASE.

Ports:
CLK_14o3M  in  1  14.318 MHz master clock; all logic on rising edge.
RESET  in  1  asynchronous, active-high reset.
PHI0  in  1  CPU phase from the generator; sampled at the RAS fall.
RASn  in  1  generator RAS timing, active low.
CASn  in  1  generator CAS timing, active low.
AX  in  1  address mux select: 1 = row, 0 = column.
HCOL  in  6  horizontal byte column (0..39 visible).
SROW  in  5  text row (0..23).
LROW  in  3  scan line within text row (VA,VB,VC).
TEXT_MODE  in  1  text display.
HIRES  in  1  hires graphics (ignored when TEXT_MODE=1).
MIXED  in  1  rows 20..23 forced to text.
PAGE2  in  1  display page 2.
CPU_A  in  16  CPU address.
CPU_RW  in  1  1 = read, 0 = write.
MA  out  7  multiplexed DRAM address.
MRASn  out  1  DRAM RAS, active low.
MCASn  out  3  per-bank CAS, active low.
MWEn  out  1  DRAM write enable, active low.
VID_LATCH  out  1  one-clock strobe: video data valid.
CPU_LATCH  out  1  one-clock strobe: CPU read data valid.
SLOT_CPU  out  1  current slot owner (1 = CPU).
CPU_RAM_HIT  out  1  the latched CPU slot address is in populated RAM.
VID_ADDR  out  16  latched video address (debug/verification).
PROTO_ERR  out  1  sticky timing-protocol error.

Behaviour:
- Reset values: MA=0, MRASn=1, MCASn=3'b111, MWEn=1, VID_LATCH=0, CPU_LATCH=0, SLOT_CPU=0, CPU_RAM_HIT=0, VID_ADDR=0, PROTO_ERR=0, FSM=IDLE.
- Reset asserted mid-access forces all strobes inactive immediately, with no glitch pulse on release.
- RASn and CASn are registered each clock. A fall or rise is detected as previous value versus current value.
- FSM states and transitions:
  - IDLE to ROW on RAS fall.
  - ROW to COL on CAS fall.
  - COL to DONE on CAS rise.
  - DONE to IDLE on RAS rise.
  - RAS rise while in ROW aborts to IDLE with no latch strobe and sets PROTO_ERR.
  - CAS fall while in IDLE is ignored and sets PROTO_ERR.
  - PROTO_ERR clears only on reset.
- At RAS fall the block latches SLOT_CPU=PHI0.
  - CPU slot: latches CPU_A and CPU_RW. CPU_RAM_HIT = (CPU_A < RAM_BANKS*16384). Bank = CPU_A[15:14].
  - Video slot: latches VID_ADDR. Video accesses are always RAM hits, in bank 0 or 1.
- Video address:
  - off = 128*(SROW mod 8) + 40*(SROW div 8) + HCOL.
  - Text (TEXT_MODE, or HIRES with MIXED and SROW>=20): TEXT_BASE*(PAGE2?2:1) + off.
  - Hires: HIRES_BASE*(PAGE2?2:1) + 1024*LROW + off.
  - Lores uses the text formula.
  - All arithmetic is 16-bit, no saturation. HCOL 40..63 is used as-is.
- Latency is one clock from the generator inputs to the DRAM outputs:
  - MA = AX ? addr[6:0] : addr[13:7].
  - MRASn = RASn.
  - MCASn[bank] = CASn only for the latched bank when the access is a hit; every other bank is held at 1.
- MWEn goes low in a CPU write slot with a RAM hit, from the clock after the CAS fall until the RAS rise.
- Strobes are one-clock pulses in the clock after the CAS rise:
  - CPU_LATCH for a CPU read with a RAM hit.
  - VID_LATCH for every video slot.
  - A non-hit CPU slot produces no CAS, no MWEn and no CPU_LATCH.
- Simultaneous RAS rise and CAS rise in COL: strobe fires, FSM goes directly to IDLE.

Test Plan:
- Reset: assert RESET with RASn=0 and CASn=0 driven, then release -> all outputs equal their reset values; the first full video slot yields exactly one VID_LATCH.
- Text page 1 video slot: SROW=0,HCOL=0 -> VID_ADDR=0x0400; SROW=1 -> 0x0480; SROW=8 -> 0x0428; SROW=23,HCOL=39 -> 0x07F7; MA sequence 0x77 then 0x0F.
- Hires page 2, LROW=7, SROW=23, HCOL=39 -> VID_ADDR=0x5FF7. With MIXED=1 the same position -> 0x0BF7.
- CPU write to 0x8123 -> SLOT_CPU=1; MA=0x23 (row) then 0x02 (column); only MCASn[2] pulses; MWEn low until the RAS rise; no CPU_LATCH.
- CPU read from 0xC030 -> CPU_RAM_HIT=0, MCASn stays 3'b111, no CPU_LATCH. With RAM_BANKS=1, a read of 0x4000 is also a non-hit.
- Protocol: RAS fall then RAS rise with no CAS -> PROTO_ERR=1, no strobe; the next normal slot still works and PROTO_ERR stays 1.
